// File: rtl/dmem_responder_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the data-memory responder:
//   state_t  - responder FSM encoding (IDLE / BUSY / RESP)
//   CNT_W    - width of the wait-state counter (LATENCY fits in 0..15)
//   DATA_W   - width of one memory word
// ----------------------------------------------------------------------------
package mem_pkg;

    localparam int CNT_W  = 4;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : mem_pkg

// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bundle between the core's load/store unit and the
// data-memory responder.
//   req    - access request, held until ready
//   we     - 1 = store, 0 = load
//   addr   - byte address (word index is addr[31:2])
//   wdata  - store data
//   rdata  - load data, valid while ready=1
//   ready  - one-cycle completion strobe
//   err    - access fault, valid while ready=1
// Modports: master = initiator (core side), slave = responder (memory side).
// ----------------------------------------------------------------------------
interface dmem_responder_if;
    import mem_pkg::*;

    logic              req;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, err
    );

endinterface : dmem_responder_if

// File: rtl/dmem_responder_mem_array.sv
// ----------------------------------------------------------------------------
// mem_array
// WORDS x DATA_W word memory with a synchronous write port and a registered
// read port.
//   clk, rst_n        - clock, asynchronous active-low reset (read register only)
//   wr_en/idx/data    - synchronous write
//   rd_en, rd_idx     - load the read register from the addressed word
//   rd_clr            - clear the read register (wins over rd_en)
//   rd_data           - registered read data
// ----------------------------------------------------------------------------
module mem_array
    import mem_pkg::*;
#(
    parameter int WORDS = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(WORDS)-1:0] wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic                     rd_clr,
    input  logic [$clog2(WORDS)-1:0] rd_idx,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // NOTE: the storage array has no reset; a reset loop over every entry
    // would prevent RAM inference, and its contents must survive reset anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // NOTE: every always_comb output gets a default on entry, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_clr) begin
            rd_data_d = '0;
        end else if (rd_en) begin
            rd_data_d = mem_q[rd_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule : mem_array

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Multi-cycle data-memory responder. Accepts one load or store at a time over
// a req/ready handshake, inserts LATENCY wait states, then completes the
// access with a one-cycle ready pulse. Misaligned or out-of-range addresses
// complete with err=1 and never touch the array.
//   clk    - system clock
//   reset  - asynchronous active-low reset
//   bus    - dmem_responder_if.slave (req/we/addr/wdata in, rdata/ready/err out)
// Parameters:
//   WORDS   - number of 32-bit words (power of two, >= 4)
//   LATENCY - wait states before completion (0..15)
// ----------------------------------------------------------------------------
module dmem_responder
    import mem_pkg::*;
#(
    parameter int WORDS   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);

    localparam int IDX_W = $clog2(WORDS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;

    logic              fault;
    logic [IDX_W-1:0]  word_idx;
    logic              wr_en;
    logic              rd_en;
    logic              rd_clr;
    logic [DATA_W-1:0] arr_rdata;

    // WORDS is a power of two, so "word index >= WORDS" is simply any set
    // address bit above the index field.
    assign fault    = (addr_q[1:0] != 2'b00) | (|addr_q[31:IDX_W+2]);
    assign word_idx = addr_q[IDX_W+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        rd_clr  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = BUSY;
                end
            end

            BUSY: begin
                // Abort is checked first so a dropped req never completes.
                if (!bus.req) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    if (fault) begin
                        err_d  = 1'b1;
                        rd_clr = 1'b1;
                    end else if (we_q) begin
                        wr_en  = 1'b1;
                        rd_clr = 1'b1;
                    end else begin
                        rd_en  = 1'b1;
                    end
                end
            end

            RESP: begin
                // Response lasts one cycle regardless of req.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    mem_array #(
        .WORDS (WORDS)
    ) u_mem_array (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (wr_en),
        .wr_idx  (word_idx),
        .wr_data (wdata_q),
        .rd_en   (rd_en),
        .rd_clr  (rd_clr),
        .rd_idx  (word_idx),
        .rd_data (arr_rdata)
    );

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.rdata = arr_rdata;

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder. Two instances share one stimulus
// driver: dut_a with LATENCY=2 and dut_b with LATENCY=0; `sel` routes req to
// one of them and selects which outputs are observed.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    bit          sel;
    logic        req_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    int          cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder_if bus_a ();
    dmem_responder_if bus_b ();

    assign bus_a.req   = req_r & ~sel;
    assign bus_a.we    = we_r;
    assign bus_a.addr  = addr_r;
    assign bus_a.wdata = wdata_r;
    assign bus_b.req   = req_r & sel;
    assign bus_b.we    = we_r;
    assign bus_b.addr  = addr_r;
    assign bus_b.wdata = wdata_r;

    logic        ready_w;
    logic        err_w;
    logic [31:0] rdata_w;
    assign ready_w = sel ? bus_b.ready : bus_a.ready;
    assign err_w   = sel ? bus_b.err   : bus_a.err;
    assign rdata_w = sel ? bus_b.rdata : bus_a.rdata;

    dmem_responder #(.WORDS(64), .LATENCY(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    dmem_responder #(.WORDS(64), .LATENCY(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          s;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
        logic [31:0] r;
        int          lat;
    } vec_t;

    typedef struct {
        logic        e;
        logic [31:0] r;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One complete access: drive at a falling edge (cycle 0), count falling
    // edges until ready, then compare against the scoreboard entry.
    task automatic do_access(input bit s, input bit w, input logic [31:0] a,
                             input logic [31:0] d, input logic exp_e,
                             input logic [31:0] exp_r, input int exp_lat,
                             input string name, output int rcyc);
        int   n;
        bit   got;
        exp_t ex;
        sb_q.push_back('{e: exp_e, r: exp_r, lat: exp_lat});
        @(negedge clk);
        sel     = s;
        we_r    = w;
        addr_r  = a;
        wdata_r = d;
        req_r   = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (ready_w) got = 1'b1;
        end
        req_r = 1'b0;
        rcyc  = cyc;
        check(got, {name, "_timeout"}, 32'(n), 32'(exp_lat));
        if (got && sb_q.size() > 0) begin
            ex = sb_q.pop_front();
            check(n == ex.lat, {name, "_latency"}, 32'(n), 32'(ex.lat));
            check(err_w === ex.e, {name, "_err"}, {31'd0, err_w}, {31'd0, ex.e});
            check(rdata_w === ex.r, {name, "_rdata"}, rdata_w, ex.r);
        end else begin
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  rc1, rc2, rc;
        bit  saw_ready;

        // Stored state carried by the table: [0x64]=7, [0x60]=0x11,
        // [0x68]=0x22, [0xFC]=0xA5A5_5A5A in dut_a; [0x0]=0xDEADBEEF in dut_b.
        vecs.push_back('{s:0, w:1, a:32'h64,  d:32'h7,        e:0, r:32'h0,        lat:4});
        vecs.push_back('{s:0, w:0, a:32'h64,  d:32'h0,        e:0, r:32'h7,        lat:4});
        vecs.push_back('{s:0, w:1, a:32'h66,  d:32'h99,       e:1, r:32'h0,        lat:4});
        vecs.push_back('{s:0, w:1, a:32'h100, d:32'h99,       e:1, r:32'h0,        lat:4});
        vecs.push_back('{s:0, w:0, a:32'h64,  d:32'h0,        e:0, r:32'h7,        lat:4});
        vecs.push_back('{s:0, w:0, a:32'h66,  d:32'h0,        e:1, r:32'h0,        lat:4});
        vecs.push_back('{s:0, w:1, a:32'h60,  d:32'h11,       e:0, r:32'h0,        lat:4});
        vecs.push_back('{s:0, w:1, a:32'h68,  d:32'h22,       e:0, r:32'h0,        lat:4});
        vecs.push_back('{s:0, w:1, a:32'hFC,  d:32'hA5A55A5A, e:0, r:32'h0,        lat:4});
        vecs.push_back('{s:0, w:0, a:32'hFC,  d:32'h0,        e:0, r:32'hA5A55A5A, lat:4});
        vecs.push_back('{s:0, w:0, a:32'h60,  d:32'h0,        e:0, r:32'h11,       lat:4});
        vecs.push_back('{s:1, w:1, a:32'h0,   d:32'hDEADBEEF, e:0, r:32'h0,        lat:2});
        vecs.push_back('{s:1, w:0, a:32'h0,   d:32'h0,        e:0, r:32'hDEADBEEF, lat:2});
        vecs.push_back('{s:1, w:0, a:32'h8000_0000, d:32'h0,  e:1, r:32'h0,        lat:2});

        // Reset held with req high: outputs stay at reset values.
        sel     = 1'b0;
        reset   = 1'b0;
        req_r   = 1'b1;
        we_r    = 1'b1;
        addr_r  = 32'h64;
        wdata_r = 32'h1234;
        repeat (3) @(negedge clk);
        check(ready_w === 1'b0, "rst_ready", {31'd0, ready_w}, 32'd0);
        check(err_w   === 1'b0, "rst_err",   {31'd0, err_w},   32'd0);
        check(rdata_w === 32'd0, "rst_rdata", rdata_w, 32'd0);
        check(bus_b.ready === 1'b0, "rst_ready_b", {31'd0, bus_b.ready}, 32'd0);
        reset = 1'b1;
        req_r = 1'b0;

        foreach (vecs[i]) begin
            do_access(vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].d,
                      vecs[i].e, vecs[i].r, vecs[i].lat, $sformatf("vec%0d", i), rc);
        end

        // ready and err drop after exactly one cycle (last vector faulted).
        @(negedge clk);
        check(ready_w === 1'b0, "pulse_ready_low", {31'd0, ready_w}, 32'd0);
        check(err_w   === 1'b0, "pulse_err_low",   {31'd0, err_w},   32'd0);

        // Back-to-back loads with LATENCY=0 complete 3 cycles apart.
        do_access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 2, "b2b_first", rc1);
        do_access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 2, "b2b_second", rc2);
        check((rc2 - rc1) == 3, "b2b_spacing", 32'(rc2 - rc1), 32'd3);

        // Abort: store 0x55 to 0x60, drop req after one BUSY cycle.
        @(negedge clk);
        sel     = 1'b0;
        we_r    = 1'b1;
        addr_r  = 32'h60;
        wdata_r = 32'h55;
        req_r   = 1'b1;
        @(negedge clk);
        req_r = 1'b0;
        saw_ready = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ready_w) saw_ready = 1'b1;
        end
        check(!saw_ready, "abort_no_ready", {31'd0, saw_ready}, 32'd0);
        do_access(1'b0, 1'b0, 32'h60, 32'h0, 1'b0, 32'h11, 4, "abort_reload", rc);

        // Mid-operation reset during BUSY of a store to 0x68.
        @(negedge clk);
        sel     = 1'b0;
        we_r    = 1'b1;
        addr_r  = 32'h68;
        wdata_r = 32'h77;
        req_r   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check(ready_w === 1'b0, "midrst_ready", {31'd0, ready_w}, 32'd0);
        check(err_w   === 1'b0, "midrst_err",   {31'd0, err_w},   32'd0);
        check(rdata_w === 32'd0, "midrst_rdata", rdata_w, 32'd0);
        saw_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ready_w) saw_ready = 1'b1;
        end
        check(!saw_ready, "midrst_no_ready", {31'd0, saw_ready}, 32'd0);
        reset = 1'b1;
        req_r = 1'b0;
        do_access(1'b0, 1'b0, 32'h68, 32'h0, 1'b0, 32'h22, 4, "midrst_reload", rc);
        do_access(1'b0, 1'b0, 32'h64, 32'h0, 1'b0, 32'h7,  4, "final_reload", rc);

        check(sb_q.size() == 0, "sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dmem_responder

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the processor's data-memory port. It replaces the zero-latency combinational dmem with a multi-cycle word memory that uses a req/ready handshake and a programmable number of wait states. The block stores 32-bit words, services one load or store at a time, and flags misaligned or out-of-range accesses. It sits between the core's load/store interface (DataAdr, WriteData, MemWrite, ReadData) and the on-chip data RAM.

Parameters:
WORDS, 64, number of 32-bit words in the array; must be a power of two, at least 4.
LATENCY, 2, wait-state cycles inserted before the access completes; legal range 0..15.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
req  input  1  access request; held high by the initiator until ready.
we  input  1  1 = store, 0 = load; sampled only when a request is accepted.
addr  input  32  byte address; word index is addr[31:2].
wdata  input  32  store data; sampled only when a request is accepted.
rdata  output  32  load data; valid only while ready=1.
ready  output  1  one-cycle completion strobe.
err  output  1  access fault; valid only while ready=1.

Behaviour:
- Reset (reset=0, asynchronous): state goes to IDLE, wait counter to 0, ready=0, err=0, rdata=0. Array contents are not cleared. Releasing reset mid-transaction leaves the block in IDLE. The aborted access never writes.
- States: IDLE, BUSY, RESP. Encoding is a typedef enum from the package.
- IDLE: when req=1 at a rising edge, latch we, addr and wdata. Load the counter with LATENCY and go to BUSY. When req=0, stay in IDLE.
- BUSY, abort: when req=0 at an edge, go to IDLE. No write occurs and ready is never pulsed. Abort takes priority over completion.
- BUSY, counting: when req=1 and counter≠0, decrement the counter.
- BUSY, completion: when req=1 and counter=0, perform the access at that edge and go to RESP.
- Fault: fault = (addr[1:0]≠0) | (addr[31:2] ≥ WORDS), using the latched addr.
- Store completion: when the access is not faulted, write wdata to the array. rdata is set to 0.
- Load completion: when the access is not faulted, register the array word into rdata.
- Faulted completion: no write. rdata is set to 0 and err is set to 1.
- RESP: ready=1 for exactly one cycle, with err and rdata stable. The next edge always goes to IDLE, whatever req is.
- Timing: if req first rises in cycle 0 and stays high, ready is high in cycle LATENCY+2. With LATENCY=0, ready is high in cycle 2.
- Handshake rule: the initiator drops req in the cycle after ready. If req is still high in IDLE, it is treated as a new request. Back-to-back accesses therefore cost LATENCY+3 cycles each.
- ready is low in IDLE and BUSY. err is low whenever ready is low. Neither output glitches combinationally; both are registered.
- Latched we, addr and wdata are ignored after acceptance. Input changes during BUSY do not affect the access.
- A read after a write to the same word (separate transactions) returns the new data.

Decomposition:
- Package mem_pkg holds: the state typedef (IDLE/BUSY/RESP), the LATENCY counter width constant (4 bits), and the word width constant (32).
- One sub-module, mem_array: a synchronous-write array with WORDS entries, a registered read port and a write enable. The FSM, counter and fault check stay in dmem_responder.

Test Plan:
- Reset check: hold reset=0 with req=1 -> ready=0, err=0, rdata=0. Release reset -> an accepted request completes normally.
- Store then load, LATENCY=2: store addr=0x64, wdata=7 -> ready in cycle 4 with err=0. Load 0x64 -> ready in cycle 4 with rdata=7.
- LATENCY=0: load addr=0x0 after a store of 0xDEADBEEF -> ready in cycle 2 with rdata=0xDEADBEEF. Two back-to-back loads complete 3 cycles apart.
- Faults: store to addr=0x66 (misaligned) -> ready with err=1 and no write. Store to 0x100 with WORDS=64 -> ready with err=1. A subsequent load of 0x64 still returns 7.
- Abort: start a store of 0x55 to 0x60, then drop req after one BUSY cycle -> no ready pulse. A later load of 0x60 returns the prior value.
- Mid-operation reset: assert reset=0 during BUSY of a store to 0x68 -> outputs return to reset values, and after release a load of 0x68 returns the unmodified value.
